median_window_builder: RTL

- Builds the sliding 1-D neighbourhood that feeds the median filter's sorting network. It sits directly upstream of the network.
- It takes a scalar sample stream framed into lines by sop/eop. For every input sample it emits one WINDOW_SIZE-wide window centred on that sample.
- Samples past the line edges are replaced by the edge sample (clamp/replicate).
- data_o is packed exactly as the network's data_i ([WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0]). data_valid_o connects directly to the network's data_valid_i.

---
 rtl/median_window_builder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/median_window_builder.sv
// median_window_builder
//   Builds the sliding WINDOW_SIZE-wide neighbourhood centred on each sample
//   of a sop/eop-framed line, replicating the edge samples past either end
//   of the line. Feeds the median sorting network directly (one window per
//   cycle, no backpressure).
//
// Ports
//   clk_i, rst_i   clock, asynchronous active-high reset
//   data_valid_i   input sample valid (accepted when ready_o is high)
//   sop_i, eop_i   first / last sample of a line, qualified by data_valid_i
//   data_i         input sample
//   ready_o        low only while flushing the tail of a line
//   data_valid_o   single-cycle window valid
//   sop_o, eop_o   first / last window of a line
//   data_o         window; index 0 oldest (k-H), index WINDOW_SIZE-1 newest (k+H)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no line open; samples without sop are dropped
// LINE  | line open; each accepted sample shifts the window
// FLUSH | H cycles replicating the last sample to emit the tail windows

module median_window_builder #(
  parameter int NUMBER_WIDTH = 10,
  parameter int WINDOW_SIZE  = 5
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      data_valid_i,
  input  logic                                      sop_i,
  input  logic                                      eop_i,
  input  logic [NUMBER_WIDTH-1:0]                   data_i,
  output logic                                      ready_o,
  output logic                                      data_valid_o,
  output logic                                      sop_o,
  output logic                                      eop_o,
  output logic [WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0]  data_o
);

  localparam int H  = (WINDOW_SIZE - 1) / 2;
  localparam int CW = $clog2(H + 1);
  localparam logic [CW-1:0] H_C    = CW'(H);
  localparam logic [CW-1:0] H_M1_C = CW'(H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LINE  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [WINDOW_SIZE-1:0][NUMBER_WIDTH-1:0] win_q, win_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic valid_q, valid_d;
  logic sop_q, sop_d;
  logic eop_q, eop_d;

  logic                    accept;
  logic                    load;
  logic                    shift;
  logic [NUMBER_WIDTH-1:0] shift_in;

  assign ready_o = (state_q != FLUSH);
  assign accept  = data_valid_i && ready_o;

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    valid_d  = 1'b0;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    shift_in = data_i;

    case (state_q)
      IDLE: begin
        if (accept && sop_i) begin
          load    = 1'b1;
          state_d = eop_i ? FLUSH : LINE;
        end
      end
      LINE: begin
        if (accept) begin
          // sop inside a line abandons it: no flush, no eop_o
          if (sop_i) begin
            load    = 1'b1;
          end else begin
            shift   = 1'b1;
          end
          if (eop_i) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        shift    = 1'b1;
        shift_in = win_q[WINDOW_SIZE-1];
        if (fcnt_q == '0) begin
          eop_d   = 1'b1;
          state_d = IDLE;
        end else begin
          fcnt_d  = fcnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // flush length counts down from H-1 to terminal count 0
    if (state_d == FLUSH && state_q != FLUSH) begin
      fcnt_d = H_M1_C;
    end

    if (load) begin
      for (int j = 0; j < WINDOW_SIZE; j++) begin
        win_d[j] = data_i;
      end
      cnt_d = '0;
    end else if (shift) begin
      for (int j = 0; j < WINDOW_SIZE - 1; j++) begin
        win_d[j] = win_q[j+1];
      end
      win_d[WINDOW_SIZE-1] = shift_in;
      cnt_d   = (cnt_q == H_C) ? H_C : cnt_q + CW'(1);
      // counter saturates at H, so ">= H" reduces to "== H"
      valid_d = (cnt_d == H_C);
      sop_d   = (cnt_q == H_M1_C);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
    end
  end

  assign data_valid_o = valid_q;
  assign sop_o        = sop_q;
  assign eop_o        = eop_q;
  assign data_o       = win_q;

endmodule
